// File: rtl/video_dnn_frame_vote_pkg.sv
// video_dnn_frame_vote_pkg: shared states, SOF index, class check and saturating increment
package video_dnn_frame_vote_pkg;
  localparam int SOF_BIT = 0;
  typedef enum logic {FRAME_IDLE, FRAME_ACCUM} frame_e;
  typedef enum logic [1:0] {SCAN_IDLE, SCAN_RUN, SCAN_HOLD} scan_e;
  function automatic logic class_ok(input logic [31:0] n, input int num_class);
    return n < 32'(num_class);
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = 32'hFFFF_FFFF >> (32 - w);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/video_dnn_vote_argmax.sv
// video_dnn_vote_argmax: snapshot bank plus one-class-per-cycle argmax with result handshake
module video_dnn_vote_argmax
  import video_dnn_frame_vote_pkg::*;
#(
  parameter int NUM_CLASS     = 10,
  parameter int VOTE_WIDTH    = 20,
  parameter int TNUMBER_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_start,
  input  logic [NUM_CLASS-1:0][VOTE_WIDTH-1:0] i_votes,
  input  logic [VOTE_WIDTH-1:0]                i_total,
  output logic [TNUMBER_WIDTH-1:0]             o_number,
  output logic [VOTE_WIDTH-1:0]                o_votes,
  output logic [VOTE_WIDTH-1:0]                o_total,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic                                 o_overrun
);
  scan_e r_state, w_state_nxt;
  logic [NUM_CLASS-1:0][VOTE_WIDTH-1:0] r_bank;
  logic [VOTE_WIDTH-1:0] r_bank_total, r_best;
  logic [TNUMBER_WIDTH-1:0] r_idx, r_best_idx;
  logic w_last, w_done;
  // next scan state; a new snapshot always restarts the scan
  always_comb begin
    w_last = 32'(r_idx) == NUM_CLASS - 1;
    w_done = (r_state == SCAN_HOLD) & !i_start;
    w_state_nxt = i_start ? SCAN_RUN :
                  ((r_state == SCAN_RUN) & w_last) ? SCAN_HOLD :
                  (r_state == SCAN_HOLD) ? SCAN_IDLE : r_state;
  end
  // scan state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= SCAN_IDLE;
    else r_state <= w_state_nxt;
  end
  // snapshot, running maximum (strict > keeps the lowest index on ties), result and overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank       <= '0;
      r_bank_total <= '0;
      r_idx        <= '0;
      r_best       <= '0;
      r_best_idx   <= '0;
      o_number     <= '0;
      o_votes      <= '0;
      o_total      <= '0;
      o_valid      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (i_start) begin
        r_bank       <= i_votes;
        r_bank_total <= i_total;
        r_idx        <= '0;
        r_best       <= '0;
        r_best_idx   <= '0;
      end else if (r_state == SCAN_RUN) begin
        if (r_bank[r_idx] > r_best) begin
          r_best     <= r_bank[r_idx];
          r_best_idx <= r_idx;
        end
        r_idx <= r_idx + TNUMBER_WIDTH'(1);
      end
      if (w_done) begin
        o_number <= r_best_idx;
        o_votes  <= r_best;
        o_total  <= r_bank_total;
        o_valid  <= 1'b1;
      end else if (o_valid & i_ready) begin
        o_valid <= 1'b0;
      end
      o_overrun <= (i_start & (r_state != SCAN_IDLE)) | (w_done & o_valid & !i_ready);
    end
  end
endmodule

// File: rtl/video_dnn_frame_vote.sv
// video_dnn_frame_vote: stream passthrough plus per-frame class histogram and vote result
module video_dnn_frame_vote
  import video_dnn_frame_vote_pkg::*;
#(
  parameter int NUM_CLASS     = 10,
  parameter int TUSER_WIDTH   = 1,
  parameter int TDATA_WIDTH   = 80,
  parameter int TNUMBER_WIDTH = 4,
  parameter int TCOUNT_WIDTH  = 4,
  parameter int Y_WIDTH       = 10,
  parameter int VOTE_WIDTH    = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TCOUNT_WIDTH-1:0]  param_threshold,
  input  logic [Y_WIDTH-1:0]       param_height,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
  input  logic [TCOUNT_WIDTH-1:0]  s_axi4s_tcount,
  input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [TNUMBER_WIDTH-1:0] m_axi4s_tnumber,
  output logic [TCOUNT_WIDTH-1:0]  m_axi4s_tcount,
  output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready,
  output logic [TNUMBER_WIDTH-1:0] m_result_number,
  output logic [VOTE_WIDTH-1:0]    m_result_votes,
  output logic [VOTE_WIDTH-1:0]    m_result_total,
  output logic                     m_result_valid,
  input  logic                     m_result_ready,
  output logic                     result_overrun
);
  frame_e r_state, w_state_nxt;
  logic w_cke, w_acc, w_sof, w_active, w_hit, w_end;
  logic [TCOUNT_WIDTH-1:0] r_threshold, w_threshold;
  logic [Y_WIDTH-1:0] r_height, w_height, r_line, w_line;
  logic [NUM_CLASS-1:0][VOTE_WIDTH-1:0] r_votes, w_votes;
  logic [VOTE_WIDTH-1:0] r_total, w_total;
  assign w_cke = !m_axi4s_tvalid | m_axi4s_tready;
  assign s_axi4s_tready = w_cke;
  // one-stage stream register
  always_ff @(posedge clk) begin
    if (reset) begin
      m_axi4s_tuser   <= '0;
      m_axi4s_tlast   <= 1'b0;
      m_axi4s_tnumber <= '0;
      m_axi4s_tcount  <= '0;
      m_axi4s_tdata   <= '0;
      m_axi4s_tvalid  <= 1'b0;
    end else if (w_cke) begin
      m_axi4s_tuser   <= s_axi4s_tuser;
      m_axi4s_tlast   <= s_axi4s_tlast;
      m_axi4s_tnumber <= s_axi4s_tnumber;
      m_axi4s_tcount  <= s_axi4s_tcount;
      m_axi4s_tdata   <= s_axi4s_tdata;
      m_axi4s_tvalid  <= s_axi4s_tvalid;
    end
  end
  // SOF pixels see freshly latched params and cleared counters, so they count like any frame pixel
  always_comb begin
    w_acc       = s_axi4s_tvalid & w_cke;
    w_sof       = w_acc & s_axi4s_tuser[SOF_BIT];
    w_active    = w_sof | (w_acc & (r_state == FRAME_ACCUM));
    w_threshold = w_sof ? param_threshold : r_threshold;
    w_height    = w_sof ? ((param_height == '0) ? Y_WIDTH'(1) : param_height) : r_height;
    w_line      = w_sof ? '0 : r_line;
    w_hit       = w_active & (s_axi4s_tcount >= w_threshold) & class_ok(32'(s_axi4s_tnumber), NUM_CLASS);
    w_end       = w_active & s_axi4s_tlast & (w_line == w_height - Y_WIDTH'(1));
    w_total     = w_sof ? '0 : r_total;
    w_votes     = w_sof ? '0 : r_votes;
    if (w_hit) begin
      w_total = VOTE_WIDTH'(sat_inc(32'(w_total), VOTE_WIDTH));
      w_votes[s_axi4s_tnumber] = VOTE_WIDTH'(sat_inc(32'(w_votes[s_axi4s_tnumber]), VOTE_WIDTH));
    end
  end
  // frame next state: frame end wins over the SOF of a one-line frame
  always_comb w_state_nxt = w_end ? FRAME_IDLE : w_sof ? FRAME_ACCUM : r_state;
  // frame state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= FRAME_IDLE;
    else r_state <= w_state_nxt;
  end
  // latched params, line counter and histogram
  always_ff @(posedge clk) begin
    if (reset) begin
      r_threshold <= '0;
      r_height    <= '0;
      r_line      <= '0;
      r_votes     <= '0;
      r_total     <= '0;
    end else if (w_active) begin
      r_threshold <= w_threshold;
      r_height    <= w_height;
      r_line      <= w_end ? '0 : s_axi4s_tlast ? w_line + Y_WIDTH'(1) : w_line;
      r_votes     <= w_votes;
      r_total     <= w_total;
    end
  end
  video_dnn_vote_argmax #(
    .NUM_CLASS(NUM_CLASS),
    .VOTE_WIDTH(VOTE_WIDTH),
    .TNUMBER_WIDTH(TNUMBER_WIDTH)
  ) u_argmax (
    .clk(clk),
    .reset(reset),
    .i_start(w_end),
    .i_votes(w_votes),
    .i_total(w_total),
    .o_number(m_result_number),
    .o_votes(m_result_votes),
    .o_total(m_result_total),
    .o_valid(m_result_valid),
    .i_ready(m_result_ready),
    .o_overrun(result_overrun)
  );
endmodule

// File: doc/video_dnn_frame_vote.md
Name: video_dnn_frame_vote

Overview:
- Sits directly downstream of the per-pixel DNN max-count stage.
- Consumes the per-pixel winning class (tnumber) and its confidence count (tcount).
- Passes the video stream through with one register stage.
- Accumulates a per-class histogram of confident pixels over each frame, then scans it sequentially. Emits one frame-level classification result (class, votes, total) on a separate valid/ready result port.

Parameters:
- NUM_CLASS, 10, number of classes; tnumber values >= NUM_CLASS are ignored.
- TUSER_WIDTH, 1, stream user width; bit 0 is start-of-frame.
- TDATA_WIDTH, 80, passthrough data width.
- TNUMBER_WIDTH, 4, class index width.
- TCOUNT_WIDTH, 4, per-pixel confidence width.
- Y_WIDTH, 10, line counter / param_height width.
- VOTE_WIDTH, 20, per-class and total vote counter width (saturating).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- param_threshold  in  TCOUNT_WIDTH  pixel counts as a vote when tcount >= threshold; sampled at SOF
- param_height  in  Y_WIDTH  lines per frame; sampled at SOF; 0 treated as 1
- s_axi4s_tuser  in  TUSER_WIDTH  bit0 = SOF
- s_axi4s_tlast  in  1  end of line
- s_axi4s_tnumber  in  TNUMBER_WIDTH  pixel winning class
- s_axi4s_tcount  in  TCOUNT_WIDTH  pixel winning count
- s_axi4s_tdata  in  TDATA_WIDTH  passthrough data
- s_axi4s_tvalid  in  1  input valid
- s_axi4s_tready  out  1  input ready
- m_axi4s_tuser / tlast / tnumber / tcount / tdata  out  same widths  registered copy of input
- m_axi4s_tvalid  out  1  output valid
- m_axi4s_tready  in  1  output ready
- m_result_number  out  TNUMBER_WIDTH  frame winning class
- m_result_votes  out  VOTE_WIDTH  votes of winning class
- m_result_total  out  VOTE_WIDTH  total votes in frame
- m_result_valid  out  1  result valid
- m_result_ready  in  1  result ready
- result_overrun  out  1  one-cycle pulse when an unconsumed result is overwritten

Behaviour:
- Reset values:
  - m_axi4s_tvalid=0, m_result_valid=0, result_overrun=0.
  - All counters 0; state IDLE.
  - Other outputs don't-care but must not be X-propagating into valid.
- Stream path:
  - cke = !m_axi4s_tvalid | m_axi4s_tready; s_axi4s_tready = cke.
  - On cke all m_axi4s_* register s_axi4s_*; latency 1.
  - The stream is never stalled by the result port.
- Accepted pixel = s_axi4s_tvalid & cke.
- Frame FSM, states IDLE, ACCUM:
  - IDLE: pixels ignored until an accepted pixel with tuser[0]=1. On that pixel:
    - latch both params;
    - clear all class counters and total, then count this pixel;
    - line=0; go ACCUM.
  - ACCUM, accepted pixel:
    - If tcount >= threshold and tnumber < NUM_CLASS: class counter and total increment, saturating at all-ones.
    - On tlast: if line == height-1, frame end, else line++.
  - SOF inside ACCUM: partial frame discarded; restart as the IDLE SOF case, with no result.
  - Frame end (the end pixel included): copy counters and total to the scan bank, start SCAN, go IDLE.
- Scan engine (separate from the frame FSM): SCAN_IDLE, SCAN_RUN, SCAN_HOLD.
  - SCAN_RUN examines one class per cycle, index 0..NUM_CLASS-1, so the result appears NUM_CLASS+1 cycles after frame end.
  - Strict greater-than compare, so a tie resolves to the lowest index.
  - All-zero votes give class 0, votes 0.
  - At completion, load the m_result_* registers, set m_result_valid=1, go SCAN_HOLD/SCAN_IDLE.
  - m_result_valid clears on m_result_valid & m_result_ready.
- Overrun:
  - If a result completes while m_result_valid=1 and m_result_ready=0: the new result overwrites the old and result_overrun pulses.
  - A frame end during SCAN_RUN restarts the scan with the new snapshot; the old scan is lost and result_overrun pulses.
- Reset mid-frame or mid-scan: everything returns to its reset values; no result is emitted.

Decomposition:
- Shared package: SOF bit index (0), class-index-valid check, saturating-increment function for VOTE_WIDTH.
- One natural sub-module, video_dnn_vote_argmax: the scan bank plus sequential argmax with result valid/ready and overrun.
- The top level holds the stream register, frame FSM and counters.

Test Plan:
- 4x2 frame, threshold 3, classes {2,2,5,2,2,7,5,2}, all tcount=4, ready=1 -> result class 2, votes 5, total 8; valid 11 cycles after the last pixel; stream out identical, 1-cycle latency.
- Tie: classes {3,1,3,1}, height 1 -> class 1, votes 2. Separately, all tcount=2 with threshold 3 -> class 0, votes 0, total 0.
- Backpressure: m_axi4s_tready toggled 50% -> s_axi4s_tready tracks cke; no pixel dropped or duplicated; votes unchanged vs the ready=1 run.
- Pixels before the first SOF, then SOF mid-frame after 3 pixels -> pre-SOF and partial pixels not counted; only the complete frame reported.
- Two 1x1-line frames (width 16) with m_result_ready=0 -> second result overwrites the first; result_overrun pulses once; then ready=1 yields the second frame's values.
- Reset asserted during SCAN_RUN -> m_result_valid stays 0; the next full frame is reported correctly.
